// File: rtl/count_checker.sv
// Sequence checker for a free-running wrap counter: expects 0,1,..,WRAP_VAL,0,... on valid cycles.
// Define COUNT_CHECKER_FORMAL_EN to embed the formal assume/assert properties.
module count_checker #(
  parameter int unsigned W        = 10,
  parameter int unsigned WRAP_VAL = 2**(W-1)-1,
  parameter int unsigned CW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cnt_valid,
  input  logic [W-1:0]  cnt,
  input  logic          clr_err,
  output logic          wrap_pulse,
  output logic          err,
  output logic          err_range,
  output logic [CW-1:0] wrap_cnt,
  output logic [CW-1:0] err_cnt
);

  localparam logic [W-1:0] WrapV = W'(WRAP_VAL);

  typedef enum logic [1:0] {StResync, StTrack, StError} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  prev_q;
  logic [W-1:0]  exp_val;
  logic          take, match, over, do_wrap, do_err;
  logic          wrap_pulse_q, err_range_q;
  logic [CW-1:0] wrap_cnt_q, err_cnt_q;

  assign exp_val = (prev_q == WrapV) ? '0 : prev_q + 1'b1;
  // A sample arriving together with clr_err is discarded.
  assign take    = cnt_valid && !clr_err;
  assign match   = (cnt == exp_val);
  assign over    = (cnt > WrapV);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StResync;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr_err) begin
      state_d = StResync;
    end else if (cnt_valid) begin
      case (state_q)
        StResync: state_d = (cnt == '0) ? StTrack : StError;
        StTrack:  state_d = match ? StTrack : StError;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    do_wrap = 1'b0;
    do_err  = 1'b0;
    if (take) begin
      case (state_q)
        StResync: do_err = (cnt != '0);
        StTrack: begin
          do_wrap = match && (prev_q == WrapV);
          do_err  = !match;
        end
        StError:  do_err = !match;
        default:  do_err = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q       <= '0;
      wrap_pulse_q <= 1'b0;
      err_range_q  <= 1'b0;
      wrap_cnt_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      wrap_pulse_q <= do_wrap;
      err_range_q  <= take && over;
      if (take) begin
        prev_q <= cnt;
      end
      if (do_wrap && (wrap_cnt_q != '1)) begin
        wrap_cnt_q <= wrap_cnt_q + 1'b1;
      end
      if (do_err && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    wrap_pulse = wrap_pulse_q;
    err        = (state_q == StError);
    err_range  = err_range_q;
    wrap_cnt   = wrap_cnt_q;
    err_cnt    = err_cnt_q;
  end

`ifdef COUNT_CHECKER_FORMAL_EN
  logic f_init_q = 1'b1;

  always_ff @(posedge clk) begin
    f_init_q <= 1'b0;
  end

  always_comb assume (rst == f_init_q);

  a_no_wrap_in_err: assert property (@(posedge clk) !(wrap_pulse && err));
  a_wrap_mono:      assert property (@(posedge clk) !rst |=> (wrap_cnt >= $past(wrap_cnt)));
  a_err_mono:       assert property (@(posedge clk) !rst |=> (err_cnt >= $past(err_cnt)));
  a_track_range:    assert property (@(posedge clk) (state_q == StTrack) |-> (prev_q <= WrapV));
`else
  // Plain synthesizable build: no properties.
`endif

endmodule
